// File: rtl/staticisor_seq.sv
// Line/function staticisor with an internal SCAN1/ACTION1/SCAN2/ACTION2 sequencer,
// gated store address and manual line entry. Optional breakpoint: STAT_BREAK_EN.
module staticisor_seq #(
  parameter int INSTR_BITS = 32,
  parameter int L_BITS     = 5,
  parameter int L_LSB      = 0,
  parameter int F_BITS     = 3,
  parameter int F_LSB      = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt,
  input  logic [INSTR_BITS-1:0] instr,
  input  logic                  instr_vld,
  input  logic [L_BITS-1:0]     man_l,
  input  logic [L_BITS-1:0]     man_key,
`ifdef STAT_BREAK_EN
  input  logic                  bp_en,
  input  logic [L_BITS-1:0]     bp_addr,
  output logic                  bp_hit,
`endif
  output logic [L_BITS-1:0]     l_stat,
  output logic [F_BITS-1:0]     f_stat,
  output logic [L_BITS-1:0]     l_addr,
  output logic [2:0]            beat,
  output logic                  action,
  output logic                  stopped
);

  generate
    if ((L_LSB + L_BITS > INSTR_BITS) || (F_LSB + F_BITS > INSTR_BITS)) begin : g_bad_field
      $error("staticisor_seq: instruction field exceeds INSTR_BITS");
    end
  endgenerate

  // The state encoding doubles as the externally visible beat code.
  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_S1   = 3'd1,
    ST_A1   = 3'd2,
    ST_S2   = 3'd3,
    ST_A2   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              step_q;
  logic [L_BITS-1:0] key_q;
  logic              by_step, by_step_nxt;
  logic              step_rise;
  logic [L_BITS-1:0] key_rise;
  logic              start;
  logic              bp_stop;
  logic              unused_instr;

  assign step_rise    = step & ~step_q;
  assign key_rise     = man_key & ~key_q;
  assign start        = run | step_rise;
  assign unused_instr = ^instr;

`ifdef STAT_BREAK_EN
  assign bp_stop = bp_en && (l_stat == bp_addr);
`else
  assign bp_stop = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    by_step_nxt = by_step;
    case (state)
      ST_STOP: begin
        if (start) begin
          state_nxt   = ST_S1;
          // A step edge only means single-instruction when the machine is not running.
          by_step_nxt = step_rise & ~run;
        end
      end
      ST_S1: state_nxt = ST_A1;
      ST_A1: if (instr_vld) state_nxt = ST_S2;
      ST_S2: state_nxt = ST_A2;
      ST_A2: begin
        if (halt || by_step || !run || bp_stop) state_nxt = ST_STOP;
        else                                    state_nxt = ST_S1;
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_STOP;
      step_q  <= 1'b0;
      key_q   <= '0;
      by_step <= 1'b0;
      l_stat  <= '0;
      f_stat  <= '0;
    end else begin
      state   <= state_nxt;
      step_q  <= step;
      key_q   <= man_key;
      by_step <= by_step_nxt;
      if (state == ST_A1 && instr_vld) begin
        l_stat <= instr[L_LSB +: L_BITS];
        f_stat <= instr[F_LSB +: F_BITS];
      end else if (state == ST_STOP && !start) begin
        // Each key edge loads only its own bit; start wins over manual entry.
        l_stat <= (l_stat & ~key_rise) | (man_l & key_rise);
      end
    end
  end

`ifdef STAT_BREAK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_hit <= 1'b0;
    end else if (state == ST_A2 && bp_stop) begin
      bp_hit <= 1'b1;
    end else if (state == ST_STOP && start) begin
      bp_hit <= 1'b0;
    end
  end
`endif

  assign beat    = state;
  assign action  = (state == ST_A1) || (state == ST_A2);
  assign stopped = (state == ST_STOP);
  assign l_addr  = l_stat & {L_BITS{state == ST_A2}};

endmodule

// File: tb/tb_staticisor_seq.sv
// Directed-plus-random bench for staticisor_seq; expected values come from a
// behavioural model of the instruction cycle (fields, beats, manual entry).
module tb_staticisor_seq;
  localparam int INSTR_BITS = 32;
  localparam int L_BITS     = 5;
  localparam int L_LSB      = 0;
  localparam int F_BITS     = 3;
  localparam int F_LSB      = 13;

  logic                  clk = 1'b0;
  logic                  rst_n, run, step, halt, instr_vld;
  logic [INSTR_BITS-1:0] instr;
  logic [L_BITS-1:0]     man_l, man_key;
  logic [L_BITS-1:0]     l_stat, l_addr;
  logic [F_BITS-1:0]     f_stat;
  logic [2:0]            beat;
  logic                  action, stopped;
`ifdef STAT_BREAK_EN
  logic                  bp_en;
  logic [L_BITS-1:0]     bp_addr;
  logic                  bp_hit;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [L_BITS-1:0] exp_l;
  logic [F_BITS-1:0] exp_f;
  logic              exp_bp;

  staticisor_seq #(
    .INSTR_BITS(INSTR_BITS), .L_BITS(L_BITS), .L_LSB(L_LSB),
    .F_BITS(F_BITS), .F_LSB(F_LSB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt(halt),
    .instr(instr), .instr_vld(instr_vld), .man_l(man_l), .man_key(man_key),
`ifdef STAT_BREAK_EN
    .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .l_stat(l_stat), .f_stat(f_stat), .l_addr(l_addr), .beat(beat),
    .action(action), .stopped(stopped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All outputs are predicted from the expected beat plus the model's line/function.
  task automatic check_outs(input string tag, input int eb);
    chk({tag, ".beat"}, 32'(beat), 32'(eb));
    chk({tag, ".action"}, 32'(action), 32'((eb == 2) || (eb == 4)));
    chk({tag, ".stopped"}, 32'(stopped), 32'(eb == 0));
    chk({tag, ".l_stat"}, 32'(l_stat), 32'(exp_l));
    chk({tag, ".f_stat"}, 32'(f_stat), 32'(exp_f));
    chk({tag, ".l_addr"}, 32'(l_addr), (eb == 4) ? 32'(exp_l) : 32'd0);
`ifdef STAT_BREAK_EN
    chk({tag, ".bp_hit"}, 32'(bp_hit), 32'(exp_bp));
`endif
  endtask

  // Inputs that must have no effect outside STOP/A2 are scrambled every cycle.
  task automatic scramble();
    halt    = 1'($urandom);
    run     = 1'($urandom);
    step    = 1'($urandom);
    man_key = L_BITS'($urandom);
    man_l   = L_BITS'($urandom);
  endtask

  // Entered with S1 just observed; returns after the A2 exit edge.
  task automatic run_pass(input logic [31:0] iw, input int waits, input logic hlt,
                          input logic rn, input logic single);
    logic stop_exp;
    instr = iw; instr_vld = 1'b0; scramble();
    tick(); check_outs("a1", 2);
    for (int w = 0; w < waits; w++) begin
      instr = $urandom; scramble();
      tick(); check_outs("a1_wait", 2);
    end
    instr = iw; instr_vld = 1'b1; scramble();
    tick();
    exp_l = L_BITS'(iw >> L_LSB);
    exp_f = F_BITS'(iw >> F_LSB);
    check_outs("s2", 3);
    instr_vld = 1'b0; instr = $urandom; scramble();
    tick(); check_outs("a2", 4);
    halt = hlt; run = rn; step = 1'b0; man_key = '0;
    stop_exp = hlt || !rn || single;
`ifdef STAT_BREAK_EN
    if (bp_en && exp_l == bp_addr) begin
      stop_exp = 1'b1;
      exp_bp = 1'b1;
    end
`endif
    tick(); check_outs("a2_exit", stop_exp ? 0 : 1);
  endtask

  initial begin
    logic [L_BITS-1:0] ml, k;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt = 1'b0; instr_vld = 1'b0;
    instr = '0; man_l = '0; man_key = '0;
`ifdef STAT_BREAK_EN
    bp_en = 1'b0; bp_addr = '0;
`endif
    exp_l = '0; exp_f = '0; exp_bp = 1'b0;

    tick(); tick(); check_outs("reset", 0);
    rst_n = 1'b1;
    repeat (10) begin tick(); check_outs("idle", 0); end

    man_l = 5'b10110; man_key = 5'b11111;
    tick(); exp_l = 5'b10110; check_outs("man_all", 0);
    man_key = '0; tick();
    man_l = '0; man_key = 5'b00001;
    tick(); check_outs("man_bit0", 0);
    man_l = 5'b01001;
    tick(); check_outs("man_held_key", 0);
    man_key = '0; tick();
    repeat (6) begin
      ml = L_BITS'($urandom); k = L_BITS'($urandom);
      man_l = ml; man_key = k;
      tick(); exp_l = (exp_l & ~k) | (ml & k); check_outs("man_rand", 0);
      man_key = '0;
      tick(); check_outs("man_release", 0);
    end

    man_l = ~exp_l; man_key = 5'b11111; run = 1'b1;
    tick(); exp_bp = 1'b0; check_outs("start_prio", 1);
    man_key = '0;

    run_pass(32'h0000_6007, 1, 1'b0, 1'b1, 1'b0);
    repeat (6) run_pass($urandom, $urandom_range(0, 3), 1'b0, 1'b1, 1'b0);
    run_pass($urandom, 0, 1'b1, 1'b1, 1'b0);
    halt = 1'b0;
    tick(); exp_bp = 1'b0; check_outs("restart", 1);
    run_pass($urandom, $urandom_range(0, 3), 1'b0, 1'b0, 1'b0);
    repeat (3) begin tick(); check_outs("stopped_idle", 0); end

    step = 1'b1;
    tick(); exp_bp = 1'b0; check_outs("step_start", 1);
    run_pass($urandom, 2, 1'b0, 1'b1, 1'b1);
    run = 1'b0;
    tick(); check_outs("step_done", 0);
    step = 1'b1;
    tick(); check_outs("step_again", 1);
    run_pass($urandom, $urandom_range(0, 3), 1'b0, 1'b0, 1'b1);
    repeat (2) begin tick(); check_outs("step_idle", 0); end

    step = 1'b1; rst_n = 1'b0;
    tick(); exp_l = '0; exp_f = '0; check_outs("rst_step_held", 0);
    rst_n = 1'b1;
    tick(); check_outs("step_after_rst", 1);
    step = 1'b0;
    run_pass($urandom, 0, 1'b0, 1'b0, 1'b1);

    run = 1'b1;
    tick(); check_outs("mid_s1", 1);
    instr = $urandom; instr_vld = 1'b0;
    tick(); check_outs("mid_a1", 2);
    instr_vld = 1'b1; rst_n = 1'b0;
    tick(); exp_l = '0; exp_f = '0; exp_bp = 1'b0; check_outs("rst_mid", 0);
    rst_n = 1'b1; run = 1'b0; instr_vld = 1'b0;
    tick(); check_outs("rst_mid_after", 0);

`ifdef STAT_BREAK_EN
    bp_en = 1'b1; bp_addr = 5'd7; run = 1'b1;
    tick(); exp_bp = 1'b0; check_outs("bp_start", 1);
    run_pass(($urandom & 32'hFFFF_FFE0) | 32'd7, 1, 1'b0, 1'b1, 1'b0);
    bp_en = 1'b0;
    tick(); exp_bp = 1'b0; check_outs("bp_clear", 1);
    run_pass($urandom, 0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/staticisor_seq.md
Name: staticisor_seq

Overview:
Parametrised, clocked successor to the line staticisor and address gates. It holds the line (L) and function (F) fields of the current instruction and runs the four-beat sequencer internally: SCAN1, ACTION1, SCAN2, ACTION2. It drives the gated store address only during the ACTION2 beat. It also supports per-bit manual line entry from the typewriter keys while the machine is stopped.

Parameters:
INSTR_BITS, 32, width of the instruction word read from the main store
L_BITS, 5, line-field width and width of the store address
L_LSB, 0, bit position of the line-field LSB in instr
F_BITS, 3, function-field width
F_LSB, 13, bit position of the function-field LSB in instr; elaboration error if a field exceeds INSTR_BITS

Ports:
clk  in  1  single clock for the whole block
rst_n  in  1  synchronous reset, active-low
run  in  1  level; 1 = machine running
step  in  1  single-instruction request; acts on its rising edge
halt  in  1  stop request from the execute unit; sampled in ACTION2
instr  in  INSTR_BITS  word read from the store
instr_vld  in  1  instr valid; ACTION1 waits for it
man_l  in  L_BITS  typewriter line switches
man_key  in  L_BITS  per-bit typewriter load keys, active-high; each bit acts on its rising edge
l_stat  out  L_BITS  staticised line field, ungated
f_stat  out  F_BITS  staticised function field
l_addr  out  L_BITS  gated store address: l_stat during ACTION2, else 0
beat  out  3  beat code: STOP=0, S1=1, A1=2, S2=3, A2=4
action  out  1  1 in A1 or A2
stopped  out  1  1 in STOP

Behaviour:
- Reset (rst_n=0 at a clk edge): state=STOP; l_stat=0; f_stat=0; l_addr=0; beat=0; action=0; stopped=1.
- Reset clears the edge-detect registers for step and man_key to 0, so a level already held at 1 when reset releases counts as a rising edge.
- Reset mid-operation aborts the instruction; a concurrent instr_vld is discarded.
- All outputs are registered, or decode registered state only. No input-to-output combinational paths.
- FSM transitions:
  - STOP -> S1 when run=1 or a rising edge of step; otherwise stay in STOP.
  - S1 -> A1 after 1 cycle.
  - A1 waits while instr_vld=0 (no timeout). With instr_vld=1 it captures l_stat=instr[L_LSB+:L_BITS] and f_stat=instr[F_LSB+:F_BITS], then moves to S2.
  - S2 -> A2 after 1 cycle.
  - A2 -> STOP if halt=1, or if the instruction was started by step, or if run=0. Otherwise A2 -> S1.
- A step-started instruction runs exactly one full cycle. It runs from S1 through A2, even if run rises mid-instruction.
- Minimum instruction duration is 4 cycles: S1, A1 (instr_vld=1), S2, A2. The new l_stat is first visible in the cycle after the A1 capture.
- l_addr equals l_stat & {L_BITS{beat==A2}}. It is 0 in every other beat, including STOP.
- Manual entry applies only in STOP. On a rising edge of man_key[i], l_stat[i] <= man_l[i]. All other bits hold. Several keys pressed in the same cycle each load their own bit.
- Keys are ignored (edges consumed, no load) in any non-STOP state. They are also ignored in the STOP cycle in which run=1 or a step edge starts the machine: start has priority.
- f_stat is never altered by manual entry.
- run=0 mid-instruction does not abort. The current instruction completes through A2, then the FSM enters STOP.
- halt outside A2 is ignored.
- Simultaneous halt=1 and run=1 in A2: halt wins, next state is STOP.
- A step edge while running is ignored and not queued.

Optional Feature:
STAT_BREAK_EN
- Defined: adds ports bp_en (in, 1), bp_addr (in, L_BITS) and bp_hit (out, 1).
- In A2, when bp_en=1 and l_stat==bp_addr, the FSM goes to STOP regardless of run. bp_hit is then set to 1.
- bp_hit stays 1 until the next STOP -> S1 transition or reset. Its reset value is 0.
- Not defined: the ports and logic are absent, and behaviour is exactly as above.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1, with run=0 -> beat=0, stopped=1, l_stat=0, f_stat=0, l_addr=0 held for 10 cycles.
- Manual entry: in STOP, man_l=5'b10110 with man_key pulsed 5'b11111, then man_l=0 with man_key pulsed 5'b00001 -> l_stat=5'b10110, then unchanged at 5'b10110 (bit0 already 0); l_addr=0 throughout.
- Free run: run=1; instr=32'h0000_6007 with instr_vld on the second cycle of A1 -> beat sequence 1,2,2,3,4,1...; l_stat=7 and f_stat=3 from S2 onward; l_addr=7 only in the A2 cycle.
- Single step: run=0, one step pulse, instr_vld=1 -> exactly one S1-A1-S2-A2 pass then STOP; a second step pulse during S2 does nothing.
- Halt priority: run=1, halt=1 during A2 -> next beat=0; halt=1 during S1 -> ignored, sequencer continues.
- Reset mid-operation: rst_n=0 during A1 while instr_vld=1 -> the next cycle shows beat=0 and l_stat=0, with no capture. With STAT_BREAK_EN, bp_addr=7, bp_en=1, instr line field 7 -> stops after A2 with bp_hit=1, and bp_hit clears on the restart.
